// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : leaf_out_arbiter
// Purpose  : Buffers each user channel in its own FIFO and merges the channels
//            onto one tagged output stream using round-robin burst grants.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_PORTS    = 2,
    parameter int PORT_ID_BITS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int BURST_MAX    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0]    din_leaf_user2interface,
    input  logic [NUM_PORTS-1:0]                 vld_user2interface,
    output logic [NUM_PORTS-1:0]                 ack_interface2user,
    output logic [PORT_ID_BITS+PAYLOAD_BITS-1:0] dout_arb,
    output logic                                 vld_arb,
    input  logic                                 ack_arb,
    input  logic                                 resend,
    output logic [PORT_ID_BITS-1:0]              grant_port,
    output logic                                 busy
);

    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam int c_pw = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_bw = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_nxt_state;
    logic [PORT_ID_BITS-1:0]   r_grant;
    logic [PORT_ID_BITS-1:0]   w_nxt_grant;
    logic [PORT_ID_BITS-1:0]   w_rr_grant;
    logic [c_bw-1:0]           r_burst;
    logic [c_bw-1:0]           w_nxt_burst;

    logic [NUM_PORTS-1:0]      w_push;
    logic [NUM_PORTS-1:0]      w_pop;
    logic [NUM_PORTS-1:0]      w_nempty;
    logic [NUM_PORTS-1:0]      w_cnt_one;
    logic [PAYLOAD_BITS-1:0]   w_head [NUM_PORTS];

    logic [c_pw-1:0]           w_gidx;
    logic                      w_gnempty;
    logic                      w_glast;
    logic                      w_pop_any;

    // Per-port FIFO; ack derives only from the registered count, so a pop in
    // the same cycle never frees space for a push.
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
            logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
            logic [c_aw-1:0]         r_wptr;
            logic [c_aw-1:0]         r_rptr;
            logic [c_cw-1:0]         r_cnt;

            assign ack_interface2user[i] = (r_cnt < c_cw'(FIFO_DEPTH));
            assign w_push[i]    = vld_user2interface[i] & ack_interface2user[i];
            assign w_pop[i]     = w_pop_any & (w_gidx == c_pw'(i));
            assign w_nempty[i]  = (r_cnt != '0);
            assign w_cnt_one[i] = (r_cnt == c_cw'(1));
            assign w_head[i]    = r_mem[r_rptr];

            always_ff @(posedge clk) begin
                if (w_push[i]) begin
                    r_mem[r_wptr] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_wptr <= r_wptr + c_aw'(w_push[i]);
                    r_rptr <= r_rptr + c_aw'(w_pop[i]);
                    r_cnt  <= r_cnt + c_cw'(w_push[i]) - c_cw'(w_pop[i]);
                end
            end
        end
    endgenerate

    assign w_gidx    = r_grant[c_pw-1:0];
    assign w_gnempty = w_nempty[w_gidx];
    // Pop that leaves the granted FIFO empty (no refill arriving this cycle).
    assign w_glast   = w_cnt_one[w_gidx] & ~w_push[w_gidx];
    assign vld_arb   = (r_state == S_GRANT) && w_gnempty && !resend;
    assign w_pop_any = vld_arb && ack_arb;

    // Round-robin search from last grant + 1; descending scan keeps the nearest hit.
    always_comb begin
        int idx;
        w_rr_grant = r_grant;
        idx        = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(r_grant) + k) % NUM_PORTS;
            if (w_nempty[idx[c_pw-1:0]]) begin
                w_rr_grant = PORT_ID_BITS'(idx);
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_burst = r_burst;
        case (r_state)
            S_IDLE: begin
                if (|w_nempty) begin
                    w_nxt_grant = w_rr_grant;
                    w_nxt_burst = '0;
                    w_nxt_state = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!resend) begin
                    if (w_pop_any) begin
                        w_nxt_burst = r_burst + c_bw'(1);
                        if (w_glast || (r_burst == c_bw'(BURST_MAX - 1))) begin
                            w_nxt_state = S_IDLE;
                        end
                    end else if (!w_gnempty) begin
                        w_nxt_state = S_IDLE;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= PORT_ID_BITS'(NUM_PORTS - 1);
            r_burst <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_burst <= w_nxt_burst;
        end
    end

    assign grant_port = r_grant;
    assign busy       = (r_state == S_GRANT);
    assign dout_arb   = (r_state == S_GRANT) ? {r_grant, w_head[w_gidx]} : '0;

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_out_arbiter
// Purpose  : Scoreboard bench for leaf_out_arbiter (two ports, burst of 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_out_arbiter;

    localparam int PB    = 32;
    localparam int NP    = 2;
    localparam int IDB   = 4;
    localparam int DEPTH = 4;
    localparam int BMAX  = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NP*PB-1:0]   din;
    logic [NP-1:0]      vld;
    logic [NP-1:0]      ack_u;
    logic [IDB+PB-1:0]  dout;
    logic               vld_arb;
    logic               ack_arb;
    logic               resend;
    logic [IDB-1:0]     grant_port;
    logic               busy;

    logic [PB-1:0]      base [NP];
    int                 seq [NP];
    int                 src_left [NP];
    logic [NP-1:0]      push_seen;
    logic [PB-1:0]      q0 [$];
    logic [PB-1:0]      q1 [$];
    logic [PB-1:0]      mon_exp;
    logic               mon_have;
    int                 n_checks = 0;
    int                 n_errors = 0;

    always #5 clk = ~clk;

    leaf_out_arbiter #(
        .PAYLOAD_BITS (PB),
        .NUM_PORTS    (NP),
        .PORT_ID_BITS (IDB),
        .FIFO_DEPTH   (DEPTH),
        .BURST_MAX    (BMAX)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack_u),
        .dout_arb                (dout),
        .vld_arb                 (vld_arb),
        .ack_arb                 (ack_arb),
        .resend                  (resend),
        .grant_port              (grant_port),
        .busy                    (busy)
    );

    assign din = {base[1] + PB'(seq[1]), base[0] + PB'(seq[0])};
    assign vld = {src_left[1] != 0, src_left[0] != 0};

    // Scoreboard: record accepted input words, compare every output handshake.
    always @(negedge clk) begin
        push_seen = '0;
        if (reset_n) begin
            if (vld[0] && ack_u[0]) begin
                q0.push_back(din[PB-1:0]);
                push_seen[0] = 1'b1;
            end
            if (vld[1] && ack_u[1]) begin
                q1.push_back(din[2*PB-1:PB]);
                push_seen[1] = 1'b1;
            end
            if (vld_arb && ack_arb) begin
                n_checks++;
                mon_have = 1'b0;
                mon_exp  = '0;
                if (dout[IDB+PB-1:PB] == 4'd0 && q0.size() > 0) begin
                    mon_exp  = q0.pop_front();
                    mon_have = 1'b1;
                end else if (dout[IDB+PB-1:PB] == 4'd1 && q1.size() > 0) begin
                    mon_exp  = q1.pop_front();
                    mon_have = 1'b1;
                end
                if (!mon_have || dout[PB-1:0] !== mon_exp) begin
                    n_errors++;
                    $display("FAIL scoreboard: got tag=%0d data=%h, expected data=%h (word expected=%0d)",
                             dout[IDB+PB-1:PB], dout[PB-1:0], mon_exp, mon_have);
                end
            end
        end
    end

    // Source: advance a port's data word after each accepted push.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (push_seen[i]) begin
                src_left[i]--;
                seq[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || q0.size() != 0 || q1.size() != 0 ||
                src_left[0] != 0 || src_left[1] != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_errors++;
            $display("FAIL %s_drain: still pending q0=%0d q1=%0d busy=%0b, required empty and idle",
                     name, q0.size(), q1.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        ack_arb     = 1'b0;
        resend      = 1'b0;
        src_left[0] = 0;
        src_left[1] = 0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({vld_arb, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_vld_busy: got %b, required 00", {vld_arb, busy});
        end
        n_checks++;
        if (dout !== '0) begin
            n_errors++;
            $display("FAIL reset_dout: got %h, required 0", dout);
        end
        n_checks++;
        if (grant_port !== 4'd1) begin
            n_errors++;
            $display("FAIL reset_grant: got %0d, required 1", grant_port);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack_u !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_ack: got %b, required 11", ack_u);
        end
    endtask

    task automatic test_single();
        ack_arb = 1'b1;
        tick();
        base[1]     = 32'hA5A5_A5A5;
        seq[1]      = 0;
        src_left[1] = 1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (vld_arb !== 1'b0) begin
            n_errors++;
            $display("FAIL single_cycle1: got vld_arb=%b, required 0", vld_arb);
        end
        @(negedge clk);
        n_checks++;
        if ({vld_arb, dout} !== {1'b1, 4'd1, 32'hA5A5_A5A5}) begin
            n_errors++;
            $display("FAIL single_cycle2: got vld=%b dout=%h, required vld=1 dout=1a5a5a5a5",
                     vld_arb, dout);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, vld_arb} !== 2'b00) begin
            n_errors++;
            $display("FAIL single_idle: got busy,vld=%b, required 00", {busy, vld_arb});
        end
        tick();
        base[1] = 32'h1000_0000;
        drain("single");
    endtask

    task automatic test_burst();
        int n;
        ack_arb = 1'b1;
        tick();
        src_left[0] = 100000;
        src_left[1] = 100000;
        n = 0;
        @(negedge clk);
        while (!vld_arb && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < BMAX; j++) begin
                n_checks++;
                if ({vld_arb, dout[IDB+PB-1:PB]} !== {1'b1, 4'(r % 2)}) begin
                    n_errors++;
                    $display("FAIL burst_word r%0d j%0d: got vld=%b tag=%0d, required vld=1 tag=%0d",
                             r, j, vld_arb, dout[IDB+PB-1:PB], r % 2);
                end
                @(negedge clk);
            end
            n_checks++;
            if (vld_arb !== 1'b0) begin
                n_errors++;
                $display("FAIL burst_bubble r%0d: got vld=%b, required 0", r, vld_arb);
            end
            @(negedge clk);
        end
        tick();
        src_left[0] = 0;
        src_left[1] = 0;
        drain("burst");
    endtask

    task automatic test_backpressure();
        ack_arb = 1'b0;
        tick();
        src_left[0] = 10;
        repeat (7) @(negedge clk);
        n_checks++;
        if (ack_u !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_ack: got %b, required 10", ack_u);
        end
        n_checks++;
        if (q0.size() != DEPTH) begin
            n_errors++;
            $display("FAIL bp_accepted: got %0d words, required %0d", q0.size(), DEPTH);
        end
        n_checks++;
        if ({vld_arb, dout[IDB+PB-1:PB]} !== {1'b1, 4'd0}) begin
            n_errors++;
            $display("FAIL bp_waiting: got vld=%b tag=%0d, required vld=1 tag=0",
                     vld_arb, dout[IDB+PB-1:PB]);
        end
        tick();
        ack_arb = 1'b1;
        drain("bp");
    endtask

    task automatic test_resend();
        int n;
        logic [IDB-1:0] g;
        ack_arb = 1'b1;
        tick();
        src_left[1] = 100000;
        n = 0;
        @(negedge clk);
        while (!vld_arb && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        tick();
        resend = 1'b1;
        g      = grant_port;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({vld_arb, busy, grant_port} !== {1'b0, 1'b1, g}) begin
                n_errors++;
                $display("FAIL resend_hold c%0d: got vld=%b busy=%b grant=%0d, required vld=0 busy=1 grant=%0d",
                         c, vld_arb, busy, grant_port, g);
            end
        end
        tick();
        resend = 1'b0;
        n = 0;
        @(negedge clk);
        while (vld_arb && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != BMAX - 4) begin
            n_errors++;
            $display("FAIL resend_burst_rest: got %0d words after resend, required %0d", n, BMAX - 4);
        end
        tick();
        src_left[1] = 0;
        drain("resend");
    endtask

    task automatic test_reset_mid();
        int n;
        ack_arb = 1'b0;
        tick();
        src_left[0] = 3;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({busy, grant_port} !== {1'b1, 4'd0} || q0.size() != 3) begin
            n_errors++;
            $display("FAIL rstmid_setup: got busy=%b grant=%0d buffered=%0d, required 1 0 3",
                     busy, grant_port, q0.size());
        end
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({vld_arb, busy, ack_u} !== 4'b0011 || dout !== '0) begin
            n_errors++;
            $display("FAIL rstmid_async: got vld=%b busy=%b ack=%b dout=%h, required 0 0 11 0",
                     vld_arb, busy, ack_u, dout);
        end
        q0.delete();
        q1.delete();
        src_left[0] = 0;
        src_left[1] = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        ack_arb     = 1'b1;
        src_left[0] = 1;
        src_left[1] = 1;
        n = 0;
        @(negedge clk);
        while (!vld_arb && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({vld_arb, dout[IDB+PB-1:PB]} !== {1'b1, 4'd0}) begin
            n_errors++;
            $display("FAIL rstmid_first_grant: got vld=%b tag=%0d, required vld=1 tag=0",
                     vld_arb, dout[IDB+PB-1:PB]);
        end
        drain("rstmid");
    endtask

    initial begin
        reset_n     = 1'b0;
        ack_arb     = 1'b0;
        resend      = 1'b0;
        base[0]     = 32'h0000_0000;
        base[1]     = 32'h1000_0000;
        seq[0]      = 0;
        seq[1]      = 0;
        src_left[0] = 0;
        src_left[1] = 0;
        push_seen   = '0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_resend();
        test_reset_mid();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL final_empty: got q0=%0d q1=%0d undelivered, required 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
